// File: rtl/uart_txd.sv
// 8N1 UART transmitter: one byte per valid/rdy handshake, serialised LSB first on txd.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module uart_txd #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       rdy,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_txd: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [BAUD_W-1:0] baud_d;
  logic [2:0]        bit_q;
  logic [7:0]        shreg_q;
  logic              txd_q;
  logic              rdy_q;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  logic baud_tick;
  logic accept;

  // The terminal count both wraps the baud counter and advances the frame by one bit.
  assign baud_tick = (baud_q == BAUD_LAST);
  assign baud_d    = baud_tick ? '0 : baud_q + 1'b1;
  assign accept    = valid && rdy_q;

  // NOTE: every register below uses <= so all of them update from the same pre-edge
  // values; a blocking = here would let later statements see half-updated state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      txd_q    <= 1'b1;
      rdy_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          txd_q  <= 1'b1;
          rdy_q  <= 1'b1;
          if (accept) begin
            shreg_q  <= data;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^data;
`endif
            state_q  <= S_START;
            txd_q    <= 1'b0;
            rdy_q    <= 1'b0;
          end
        end

        S_START: begin
          baud_q <= baud_d;
          if (baud_tick) begin
            state_q <= S_DATA;
            txd_q   <= shreg_q[0];
          end
        end

        S_DATA: begin
          baud_q <= baud_d;
          if (baud_tick) begin
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= parity_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              shreg_q <= {1'b0, shreg_q[7:1]};
              txd_q   <= shreg_q[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          baud_q <= baud_d;
          if (baud_tick) begin
            state_q <= S_STOP;
            txd_q   <= 1'b1;
          end
        end
`endif

        S_STOP: begin
          baud_q <= baud_d;
          if (baud_tick) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b1;
            txd_q   <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          rdy_q   <= 1'b1;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign rdy  = rdy_q;
  assign txd  = txd_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_txd.sv
// Directed bench for uart_txd at CLKS_PER_BIT = 16; expected frames are built from the byte.
// Compile with UART_TX_PARITY_EN defined to exercise the parity build.
module tb_uart_txd;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic       rdy;
  logic       txd;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  uart_txd #(.CLK_FREQ(160), .BAUD_RATE(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .data  (data),
    .rdy   (rdy),
    .txd   (txd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Present a byte and wait (bounded) for the accepting edge; returns in start-bit cycle 0.
  task automatic handshake(input logic [7:0] b, input logic keep_valid);
    int n;
    valid = 1'b1;
    data  = b;
    n = 0;
    while (!rdy && n < 400) begin
      tick();
      n++;
    end
    check("rdy_before_handshake", rdy, 1'b1);
    tick();
    if (!keep_valid) valid = 1'b0;
  endtask

  // Check every cycle of a frame; optionally pulse valid with 0x3C at cycle pulse_at.
  task automatic check_frame(input logic [7:0] b, input int pulse_at, input logic [7:0] next_data);
    for (int cyc = 0; cyc < NBITS * CPB; cyc++) begin
      check($sformatf("txd %02h bit%0d cyc%0d", b, cyc / CPB, cyc), txd, frame_bit(b, cyc / CPB));
      check($sformatf("rdy_low %02h cyc%0d", b, cyc), rdy, 1'b0);
      check($sformatf("busy %02h cyc%0d", b, cyc), busy, 1'b1);
      if (cyc == 0) data = next_data;
      if (cyc == pulse_at) begin
        valid = 1'b1;
        data  = 8'h3C;
      end else if (cyc == pulse_at + 1) begin
        valid = 1'b0;
      end
      tick();
    end
    check($sformatf("rdy_after %02h", b), rdy, 1'b1);
    check($sformatf("busy_after %02h", b), busy, 1'b0);
    check($sformatf("txd_idle_after %02h", b), txd, 1'b1);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check({tag, "_txd"}, txd, 1'b1);
      check({tag, "_rdy"}, rdy, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
      tick();
    end
  endtask

  initial begin
    // Reset held with valid asserted: no frame may start.
    rst   = 1'b0;
    valid = 1'b1;
    data  = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_txd", txd, 1'b1);
      check("reset_rdy", rdy, 1'b1);
      check("reset_busy", busy, 1'b0);
    end
    rst   = 1'b1;
    valid = 1'b0;
    check_quiet("post_reset", 8);

    // Single frame 0xA5: 0,1,0,1,0,0,1,0,1,1 (8N1).
    handshake(8'hA5, 1'b0);
    check_frame(8'hA5, -10, 8'hA5);
    check_quiet("after_a5", 4);

    // valid held: 0x00 then 0xFF with exactly one idle cycle between frames.
    handshake(8'h00, 1'b1);
    check_frame(8'h00, -10, 8'hFF);
    tick();
    valid = 1'b0;
    check_frame(8'hFF, -10, 8'hFF);
    check_quiet("after_ff", 4);

    // valid pulse with 0x3C mid-DATA is ignored.
    handshake(8'h81, 1'b0);
    check_frame(8'h81, 4 * CPB + 5, 8'h81);
    check_quiet("no_extra_frame", 20);

    // Reset during data bit 4 of 0x55 abandons the frame.
    handshake(8'h55, 1'b0);
    for (int cyc = 0; cyc < 5 * CPB + 8; cyc++) begin
      check($sformatf("txd 55 partial cyc%0d", cyc), txd, frame_bit(8'h55, cyc / CPB));
      tick();
    end
    check("busy_before_abort", busy, 1'b1);
    rst = 1'b0;
    tick();
    check("abort_txd", txd, 1'b1);
    check("abort_rdy", rdy, 1'b1);
    check("abort_busy", busy, 1'b0);
    rst = 1'b1;
    check_quiet("after_abort", 3);
    handshake(8'h55, 1'b0);
    check_frame(8'h55, -10, 8'h55);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 -> parity 1, 0x03 -> parity 0; frame is 176 clocks.
    check_quiet("pre_parity", 2);
    handshake(8'h07, 1'b0);
    check_frame(8'h07, -10, 8'h07);
    handshake(8'h03, 1'b0);
    check_frame(8'h03, -10, 8'h03);
`endif

    check_quiet("final", 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
